// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus types: DMA sequencer state enum and default bus widths.
// Imported by the DMA sequencer, its counter and the bus stage.
package z80_bus_pkg;

  localparam int Z80_ADDR_W = 16;
  localparam int Z80_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    READ,
    WRITE,
    RELEASE
  } dma_state_t;

endpackage

// File: rtl/z80_dma_counter.sv
// DMA address incrementers and byte down-counter.
// Ports: load/step/clear controls, start values in, current/next addrs, countZero/countLast out.
module z80_dma_counter
  import z80_bus_pkg::*;
#(
  parameter int ADDR_W = Z80_ADDR_W,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              clear,
  input  logic [ADDR_W-1:0] srcLoad,
  input  logic [ADDR_W-1:0] dstLoad,
  input  logic [LEN_W-1:0]  lenLoad,
  output logic [ADDR_W-1:0] srcAddr,
  output logic [ADDR_W-1:0] srcAddrInc,
  output logic [ADDR_W-1:0] dstAddr,
  output logic              countZero,
  output logic              countLast
);

  logic [LEN_W-1:0]  count;
  logic [ADDR_W-1:0] dstAddrInc;

  assign srcAddrInc = srcAddr + ADDR_W'(1);
  assign dstAddrInc = dstAddr + ADDR_W'(1);
  assign countZero  = (count == '0);
  assign countLast  = (count == LEN_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      srcAddr <= '0;
      dstAddr <= '0;
      count   <= '0;
    end else if (load) begin
      srcAddr <= srcLoad;
      dstAddr <= dstLoad;
      count   <= lenLoad;
    end else if (clear) begin
      count   <= '0;
    end else if (step) begin
      srcAddr <= srcAddrInc;
      dstAddr <= dstAddrInc;
      count   <= count - LEN_W'(1);
    end
  end

endmodule

// File: rtl/z80_dma_sequencer.sv
// Z80 memory-to-memory DMA: bus request handshake, then read/write strobes per byte.
// Ports: start/srcAddr/dstAddr/length in; busy/done/error out; nBUSREQ/nBUSAK
// handshake; readData/writeData/busAddress/busWriteData/busReadData/busAck to bus stage.
// Build option: Z80_DMA_BURST_EN keeps the bus for the whole block (else cycle-steal).
module z80_dma_sequencer
  import z80_bus_pkg::*;
#(
  parameter int ADDR_W = Z80_ADDR_W,
  parameter int DATA_W = Z80_DATA_W,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] srcAddr,
  input  logic [ADDR_W-1:0] dstAddr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              nBUSREQ,
  input  logic              nBUSAK,
  output logic              readData,
  output logic              writeData,
  output logic [ADDR_W-1:0] busAddress,
  output logic [DATA_W-1:0] busWriteData,
  input  logic [DATA_W-1:0] busReadData,
  input  logic              busAck
);

  dma_state_t state, stateNext;

  logic              nBusReqNext;
  logic              readNext;
  logic              writeNext;
  logic              busyNext;
  logic              doneNext;
  logic              errorNext;
  logic [ADDR_W-1:0] addrNext;
  logic [DATA_W-1:0] wdataNext;

  logic              cntLoad;
  logic              cntStep;
  logic              cntClear;
  logic [ADDR_W-1:0] curSrc;
  logic [ADDR_W-1:0] curSrcInc;
  logic [ADDR_W-1:0] curDst;
  logic              countZero;
  logic              countLast;

  z80_dma_counter #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) counter (
    .clock     (clock),
    .reset     (reset),
    .load      (cntLoad),
    .step      (cntStep),
    .clear     (cntClear),
    .srcLoad   (srcAddr),
    .dstLoad   (dstAddr),
    .lenLoad   (length),
    .srcAddr   (curSrc),
    .srcAddrInc(curSrcInc),
    .dstAddr   (curDst),
    .countZero (countZero),
    .countLast (countLast)
  );

  // Outputs are registered from these next values, so each
  // decision here shows on the pins one edge later.
  always_comb begin
    stateNext   = state;
    nBusReqNext = nBUSREQ;
    readNext    = 1'b0;
    writeNext   = 1'b0;
    busyNext    = busy;
    doneNext    = 1'b0;
    errorNext   = error;
    addrNext    = busAddress;
    wdataNext   = busWriteData;
    cntLoad     = 1'b0;
    cntStep     = 1'b0;
    cntClear    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          cntLoad   = 1'b1;
          errorNext = 1'b0;
          if (length == '0) begin
            doneNext = 1'b1;
          end else begin
            busyNext    = 1'b1;
            nBusReqNext = 1'b0;
            stateNext   = REQUEST;
          end
        end
      end
      REQUEST: begin
        nBusReqNext = 1'b0;
        if (!nBUSAK) begin
          readNext  = 1'b1;
          addrNext  = curSrc;
          stateNext = READ;
        end
      end
      READ: begin
        if (nBUSAK) begin
          errorNext   = 1'b1;
          cntClear    = 1'b1;
          nBusReqNext = 1'b1;
          stateNext   = RELEASE;
        end else if (busAck) begin
          writeNext = 1'b1;
          addrNext  = curDst;
          wdataNext = busReadData;
          stateNext = WRITE;
        end else begin
          readNext = 1'b1;
        end
      end
      WRITE: begin
        if (nBUSAK) begin
          errorNext   = 1'b1;
          cntClear    = 1'b1;
          nBusReqNext = 1'b1;
          stateNext   = RELEASE;
        end else if (busAck) begin
          cntStep = 1'b1;
`ifdef Z80_DMA_BURST_EN
          // countLast: this ack takes the count to zero.
          if (!countLast) begin
            readNext  = 1'b1;
            addrNext  = curSrcInc;
            stateNext = READ;
          end else begin
            nBusReqNext = 1'b1;
            stateNext   = RELEASE;
          end
`else
          nBusReqNext = 1'b1;
          stateNext   = RELEASE;
`endif
        end else begin
          writeNext = 1'b1;
        end
      end
      RELEASE: begin
        nBusReqNext = 1'b1;
        if (nBUSAK) begin
          if (countZero) begin
            doneNext  = 1'b1;
            busyNext  = 1'b0;
            stateNext = IDLE;
          end else begin
            nBusReqNext = 1'b0;
            stateNext   = REQUEST;
          end
        end
      end
      default: begin
        nBusReqNext = 1'b1;
        stateNext   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      nBUSREQ      <= 1'b1;
      readData     <= 1'b0;
      writeData    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      busAddress   <= '0;
      busWriteData <= '0;
    end else begin
      state        <= stateNext;
      nBUSREQ      <= nBusReqNext;
      readData     <= readNext;
      writeData    <= writeNext;
      busy         <= busyNext;
      done         <= doneNext;
      error        <= errorNext;
      busAddress   <= addrNext;
      busWriteData <= wdataNext;
    end
  end

endmodule

// File: tb/tb_z80_dma_sequencer.sv
// Directed bench for z80_dma_sequencer: memory/bus-stage model, CPU grant model.
// Covers reset, 3-byte copy, zero length, address wrap, lost grant, async reset.
module tb_z80_dma_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] srcAddr = '0;
  logic [15:0] dstAddr = '0;
  logic [7:0]  length = '0;
  logic        busy, done, error, nBUSREQ, nBUSAK;
  logic        readData, writeData, busAck;
  logic [15:0] busAddress;
  logic [7:0]  busWriteData, busReadData;

  logic        ackEn = 1'b1;
  logic        forceLost = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  reqPipe = 2'b11;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  z80_dma_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .srcAddr     (srcAddr),
    .dstAddr     (dstAddr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .nBUSREQ     (nBUSREQ),
    .nBUSAK      (nBUSAK),
    .readData    (readData),
    .writeData   (writeData),
    .busAddress  (busAddress),
    .busWriteData(busWriteData),
    .busReadData (busReadData),
    .busAck      (busAck)
  );

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  // CPU grants two cycles after request; bus stage acks with zero wait.
  assign nBUSAK      = forceLost | reqPipe[1];
  assign busAck      = ackEn & (readData | writeData) & ~nBUSAK;
  assign busReadData = pat(busAddress);

  always @(posedge clock) reqPipe <= {reqPipe[0], nBUSREQ};

  logic [7:0]  mem [0:65535];
  logic [15:0] rdAddr [0:7];
  logic [15:0] wrAddr [0:7];
  int readCnt, writeCnt, doneCnt, grantCnt, reqRise;
  logic sawReqLow, prevAk, prevReq;

  always @(posedge clock) begin
    if (clr) begin
      readCnt   <= 0;
      writeCnt  <= 0;
      doneCnt   <= 0;
      grantCnt  <= 0;
      reqRise   <= 0;
      sawReqLow <= 1'b0;
    end else begin
      if (readData && busAck) begin
        rdAddr[readCnt[2:0]] <= busAddress;
        readCnt <= readCnt + 1;
      end
      if (writeData && busAck) begin
        mem[busAddress] <= busWriteData;
        wrAddr[writeCnt[2:0]] <= busAddress;
        writeCnt <= writeCnt + 1;
      end
      if (done) doneCnt <= doneCnt + 1;
      if (prevAk && !nBUSAK) grantCnt <= grantCnt + 1;
      if (!prevReq && nBUSREQ) reqRise <= reqRise + 1;
      if (!nBUSREQ) sawReqLow <= 1'b1;
    end
    prevAk  <= nBUSAK;
    prevReq <= nBUSREQ;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic doStart(input logic [15:0] s, input logic [15:0] d,
                         input logic [7:0] n);
    @(negedge clock);
    srcAddr = s;
    dstAddr = d;
    length  = n;
    start   = 1'b1;
    @(negedge clock);
    start   = 1'b0;
  endtask

  task automatic clearMon();
    @(negedge clock);
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (doneCnt == 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk({tag, " done seen"}, 32'(doneCnt != 0), 1);
    repeat (2) @(negedge clock);
  endtask

  int gExp, rExp, n;

  initial begin
`ifdef Z80_DMA_BURST_EN
    gExp = 1;
    rExp = 1;
`else
    gExp = 2;
    rExp = 2;
`endif
    repeat (2) @(negedge clock);
    chk("rst nBUSREQ", nBUSREQ, 1);
    chk("rst readData", readData, 0);
    chk("rst writeData", writeData, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst busAddress", busAddress, 0);
    chk("rst busWriteData", busWriteData, 0);
    reset = 1'b0;
    clearMon();

    doStart(16'h1000, 16'h2000, 8'd3);
    chk("t1 busy", busy, 1);
    chk("t1 nBUSREQ low", nBUSREQ, 0);
    waitDone("t1", 200);
    chk("t1 mem0", mem[16'h2000], pat(16'h1000));
    chk("t1 mem1", mem[16'h2001], pat(16'h1001));
    chk("t1 mem2", mem[16'h2002], pat(16'h1002));
    chk("t1 reads", readCnt, 3);
    chk("t1 writes", writeCnt, 3);
    chk("t1 doneCnt", doneCnt, 1);
    chk("t1 error", error, 0);
    chk("t1 busy end", busy, 0);
    chk("t1 nBUSREQ end", nBUSREQ, 1);
    chk("t1 grants", grantCnt, (gExp == 1) ? 1 : 3);

    clearMon();
    doStart(16'h0000, 16'h0000, 8'd0);
    chk("t2 done", done, 1);
    @(negedge clock);
    chk("t2 done pulse", done, 0);
    chk("t2 no request", sawReqLow, 0);

    clearMon();
    doStart(16'hFFFF, 16'h7FFE, 8'd2);
    waitDone("t3", 200);
    chk("t3 rd0", rdAddr[0], 16'hFFFF);
    chk("t3 rd1", rdAddr[1], 16'h0000);
    chk("t3 wr0", wrAddr[0], 16'h7FFE);
    chk("t3 wr1", wrAddr[1], 16'h7FFF);
    chk("t3 mem0", mem[16'h7FFE], pat(16'hFFFF));
    chk("t3 mem1", mem[16'h7FFF], pat(16'h0000));

    clearMon();
    doStart(16'h3000, 16'h4000, 8'd4);
    n = 0;
    while (!(writeData && writeCnt == 1) && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("t4 reach byte2 write", 32'(writeData && writeCnt == 1), 1);
    ackEn     = 1'b0;
    forceLost = 1'b1;
    @(negedge clock);
    chk("t4 strobe drop", writeData, 0);
    chk("t4 error", error, 1);
    chk("t4 nBUSREQ", nBUSREQ, 1);
    waitDone("t4", 20);
    chk("t4 doneCnt", doneCnt, 1);
    chk("t4 writes", writeCnt, 1);
    chk("t4 mem0", mem[16'h4000], pat(16'h3000));
    chk("t4 error sticky", error, 1);
    chk("t4 busy end", busy, 0);
    forceLost = 1'b0;
    ackEn     = 1'b1;
    repeat (3) @(negedge clock);

    clearMon();
    doStart(16'h1100, 16'h2100, 8'd2);
    chk("t6 error cleared", error, 0);
    chk("t6 busy", busy, 1);
    waitDone("t6", 200);
    chk("t6 grants", grantCnt, gExp);
    chk("t6 req rises", reqRise, rExp);
    chk("t6 writes", writeCnt, 2);
    chk("t6 mem1", mem[16'h2101], pat(16'h1101));

    clearMon();
    doStart(16'h5000, 16'h6000, 8'd3);
    n = 0;
    while (!readData && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("t5 reach read", readData, 1);
    reset = 1'b1;
    #1;
    chk("t5 async readData", readData, 0);
    chk("t5 async nBUSREQ", nBUSREQ, 1);
    chk("t5 async busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    clearMon();
    doStart(16'h5000, 16'h6000, 8'd1);
    waitDone("t5", 200);
    chk("t5 writes", writeCnt, 1);
    chk("t5 mem", mem[16'h6000], pat(16'h5000));
    chk("t5 error", error, 0);
    chk("t5 doneCnt", doneCnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
